// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: one WIDTH-bit word per valid/ready handshake, emitted
// as a gapless bit stream with bit-valid and last strobes. Optional even parity bit: PISO_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_serial,
  output logic             o_bit_valid,
  output logic             o_last,
  output logic             o_busy
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shift;
  logic [CW-1:0]    cnt;
  logic             head_bit;
  logic             data_last;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  // The bit on the wire is always the leading end of sreg; shifting pulls the next one in.
  always_comb begin
    sreg_shift = sreg;
    head_bit   = 1'b0;
    if (MSB_FIRST) begin
      sreg_shift = {sreg[WIDTH-2:0], 1'b0};
      head_bit   = sreg[WIDTH-1];
    end else begin
      sreg_shift = {1'b0, sreg[WIDTH-1:1]};
      head_bit   = sreg[0];
    end
  end

  assign data_last = (state == ST_SHIFT) && (cnt == LAST_IDX);
  assign accept    = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      // A load in the last-bit cycle overrides the return to idle, keeping the stream gapless.
      state <= ST_SHIFT;
      sreg  <= i_data;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par   <= ^i_data;
`endif
    end else begin
      case (state)
        ST_SHIFT: begin
          if (cnt == LAST_IDX) begin
`ifdef PISO_PARITY_EN
            state <= ST_PARITY;
`else
            state <= ST_IDLE;
`endif
            sreg  <= '0;
            cnt   <= '0;
          end else begin
            sreg  <= sreg_shift;
            cnt   <= cnt + CW'(1);
          end
        end
`ifdef PISO_PARITY_EN
        ST_PARITY: begin
          state <= ST_IDLE;
          par   <= 1'b0;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_serial = 1'b0;
    case (state)
      ST_SHIFT:  o_serial = head_bit;
`ifdef PISO_PARITY_EN
      ST_PARITY: o_serial = par;
`endif
      default:   o_serial = 1'b0;
    endcase
  end

`ifdef PISO_PARITY_EN
  assign o_last = (state == ST_PARITY);
`else
  assign o_last = data_last;
`endif

  assign o_bit_valid = (state != ST_IDLE);
  assign o_busy      = o_bit_valid;
  assign o_ready     = (state == ST_IDLE) || o_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first and LSB-first instances share stimulus
// and are compared each cycle against a bit-queue model of the expected serial stream.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready_m, ser_m, bv_m, last_m, busy_m;
  logic       ready_l, ser_l, bv_l, last_l, busy_l;

  int checks = 0;
  int errors = 0;

  bit qm[$];
  bit ql[$];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready_m), .o_serial(ser_m), .o_bit_valid(bv_m), .o_last(last_m), .o_busy(busy_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready_l), .o_serial(ser_l), .o_bit_valid(bv_l), .o_last(last_l), .o_busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame as transmitted, first bit at index FLEN-1.
  function automatic logic [FLEN-1:0] frame_vec(input logic [7:0] d, input bit msb);
    logic [FLEN-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[FLEN-1-i] = msb ? d[7-i] : d[i];
`ifdef PISO_PARITY_EN
    v[0] = ^d;
`endif
    return v;
  endfunction

  // Model: queue of bits still to appear; head is the bit on the wire this cycle.
  always @(posedge clk or negedge rst_n) begin : model
    logic [FLEN-1:0] fm, fl;
    logic acc;
    if (!rst_n) begin
      qm.delete();
      ql.delete();
    end else begin
      acc = valid && (qm.size() <= 1);
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) begin
        fm = frame_vec(data, 1'b1);
        fl = frame_vec(data, 1'b0);
        for (int i = FLEN - 1; i >= 0; i--) begin
          qm.push_back(fm[i]);
          ql.push_back(fl[i]);
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit ev, es, el, er;
    ev = qm.size() > 0;
    es = ev ? qm[0] : 1'b0;
    el = qm.size() == 1;
    er = qm.size() <= 1;
    chk("m_ready", 32'(ready_m), 32'(er));
    chk("m_serial", 32'(ser_m), 32'(es));
    chk("m_bit_valid", 32'(bv_m), 32'(ev));
    chk("m_last", 32'(last_m), 32'(el));
    chk("m_busy", 32'(busy_m), 32'(ev));
    ev = ql.size() > 0;
    es = ev ? ql[0] : 1'b0;
    el = ql.size() == 1;
    er = ql.size() <= 1;
    chk("l_ready", 32'(ready_l), 32'(er));
    chk("l_serial", 32'(ser_l), 32'(es));
    chk("l_bit_valid", 32'(bv_l), 32'(ev));
    chk("l_last", 32'(last_l), 32'(el));
    chk("l_busy", 32'(busy_l), 32'(ev));
  end

  task automatic run_frame(input logic [7:0] d, input logic [31:0] exp_m, input logic [31:0] exp_l,
                           input string name);
    logic [31:0] gm, gl, lm;
    gm = '0; gl = '0; lm = '0;
    @(negedge clk); valid = 1'b1; data = d;
    @(negedge clk); valid = 1'b0;
    for (int k = 0; k < FLEN; k++) begin
      gm[FLEN-1-k] = ser_m;
      gl[FLEN-1-k] = ser_l;
      lm[FLEN-1-k] = last_m;
      @(negedge clk);
    end
    chk({name, "_msb_stream"}, gm, exp_m);
    chk({name, "_lsb_stream"}, gl, exp_l);
    chk({name, "_last_mask"}, lm, 32'h1);
    chk({name, "_idle_after"}, 32'(bv_m), 32'h0);
  endtask

  // mode 0: valid held across two words; mode 1: second word raised mid-frame and changed before accept.
  task automatic run_two(input logic [7:0] d1, input logic [7:0] d2, input bit mode,
                         input logic [31:0] exp, input string name);
    logic [31:0] g, rm, lm, vm;
    g = '0; rm = '0; lm = '0; vm = '0;
    @(negedge clk); valid = 1'b1; data = d1;
    @(negedge clk);
    if (mode) valid = 1'b0;
    else data = d2;
    for (int k = 0; k < 2 * FLEN; k++) begin
      if (mode && k == 3) begin valid = 1'b1; data = 8'hFF; end
      if (mode && k == 5) data = d2;
      if (k == FLEN) valid = 1'b0;
      g[2*FLEN-1-k]  = ser_m;
      rm[2*FLEN-1-k] = ready_m;
      lm[2*FLEN-1-k] = last_m;
      vm[2*FLEN-1-k] = bv_m;
      @(negedge clk);
    end
    chk({name, "_stream"}, g, exp);
    chk({name, "_ready_mask"}, rm, (32'h1 << FLEN) | 32'h1);
    chk({name, "_last_mask"}, lm, (32'h1 << FLEN) | 32'h1);
    chk({name, "_valid_mask"}, vm, (32'h1 << (2 * FLEN)) - 32'h1);
    chk({name, "_idle_after"}, 32'(bv_m), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;

`ifdef PISO_PARITY_EN
    chk("model_07_msb", 32'(frame_vec(8'h07, 1'b1)), 32'h00F);
    chk("model_01_lsb", 32'(frame_vec(8'h01, 1'b0)), 32'h101);
`else
    chk("model_07_msb", 32'(frame_vec(8'h07, 1'b1)), 32'h07);
    chk("model_01_lsb", 32'(frame_vec(8'h01, 1'b0)), 32'h80);
`endif

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(ready_m), 32'h1);
      chk("rst_bit_valid", 32'(bv_m), 32'h0);
      chk("rst_serial", 32'(ser_m), 32'h0);
      chk("rst_last", 32'(last_m), 32'h0);
    end
    #2 rst_n = 1'b1;

`ifdef PISO_PARITY_EN
    run_frame(8'hA5, 32'h14A, 32'h14A, "a5");
    run_frame(8'h01, 32'h003, 32'h101, "x01");
    run_frame(8'h07, 32'h00F, 32'h1C1, "x07");
    run_two(8'hA5, 8'h3C, 1'b0, 32'h29478, "b2b");
    run_two(8'hA5, 8'h81, 1'b1, 32'h29502, "late");
`else
    run_frame(8'hA5, 32'hA5, 32'hA5, "a5");
    run_frame(8'h01, 32'h01, 32'h80, "x01");
    run_frame(8'h07, 32'h07, 32'hE0, "x07");
    run_two(8'hA5, 8'h3C, 1'b0, 32'hA53C, "b2b");
    run_two(8'hA5, 8'h81, 1'b1, 32'hA581, "late");
`endif

    // Reset in the middle of a frame.
    @(negedge clk); valid = 1'b1; data = 8'hF0;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_serial", 32'(ser_m), 32'h0);
    chk("midrst_bit_valid", 32'(bv_m), 32'h0);
    chk("midrst_last", 32'(last_m), 32'h0);
    chk("midrst_busy", 32'(busy_m), 32'h0);
    chk("midrst_ready", 32'(ready_m), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_bit_valid", 32'(bv_m), 32'h0);
      chk("postrst_ready", 32'(ready_m), 32'h1);
    end

    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 3) != 0);
      data  = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk); valid = 1'b0;
    repeat (2 * FLEN) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
